// File: rtl/vga_fml_mport_arb.sv
// N-channel Wishbone-to-FML arbiter: channel 0 has fixed priority, channels 1..N_CH-1 share round-robin.
// Optional anti-starvation for channels >=1 is enabled by defining VGA_FML_ARB_STARVE_EN.
module vga_fml_mport_arb #(
  parameter int N_CH         = 3,
  parameter int FML_DEPTH    = 20,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic [N_CH*(FML_DEPTH-1)-1:0]   ch_adr_i,
  input  logic [2*N_CH-1:0]               ch_sel_i,
  input  logic [N_CH-1:0]                 ch_we_i,
  input  logic [16*N_CH-1:0]              ch_dat_i,
  input  logic [N_CH-1:0]                 ch_stb_i,
  output logic [15:0]                     ch_dat_o,
  output logic [N_CH-1:0]                 ch_ack_o,
  output logic [FML_DEPTH-1:0]            fml_adr_o,
  output logic                            fml_stb_o,
  output logic                            fml_we_o,
  output logic [1:0]                      fml_sel_o,
  output logic [15:0]                     fml_do,
  input  logic                            fml_ack_i,
  input  logic [15:0]                     fml_di
);

  // state | meaning
  // IDLE  | arbitrate among ch_stb_i, latch winner's request into fml_* registers
  // BUS   | fml_stb_o high, fml_* held until fml_ack_i
  // DONE  | ch_ack_o pulse visible; no arbitration so stale stb is never re-granted

  localparam int AW = FML_DEPTH - 1;
  localparam int GW = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   rr_win;
  logic [GW-1:0]   win;
  logic            rr_req;
  logic            starve_hit;
  logic            win_rr;
  logic            take;
  int              rank;
  int              best_rank;

  logic [AW-1:0]   win_adr;
  logic [1:0]      win_sel;
  logic            win_we;
  logic [15:0]     win_dat;

  // Round-robin candidate: nearest requesting channel after rr_ptr, wrapping N_CH-1 -> 1.
  always_comb begin
    rr_win    = rr_ptr;
    rr_req    = 1'b0;
    best_rank = N_CH;
    rank      = 0;
    for (int c = 1; c < N_CH; c++) begin
      rank = (c > int'(rr_ptr)) ? (c - int'(rr_ptr)) : (c - int'(rr_ptr) + N_CH - 1);
      if (ch_stb_i[c] && (rank < best_rank)) begin
        best_rank = rank;
        rr_win    = GW'(c);
        rr_req    = 1'b1;
      end
    end
  end

`ifdef VGA_FML_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;

  assign starve_hit = rr_req && (starve_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (win_rr)
        starve_cnt <= '0;
      else if (rr_req && (starve_cnt != CW'(STARVE_LIMIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  assign win_rr = !ch_stb_i[0] || starve_hit;
  assign win    = win_rr ? rr_win : '0;
  assign take   = (state == IDLE) && (ch_stb_i[0] || rr_req);

  always_comb begin
    win_adr = '0;
    win_sel = '0;
    win_we  = 1'b0;
    win_dat = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (win == GW'(c)) begin
        win_adr = ch_adr_i[c*AW +: AW];
        win_sel = ch_sel_i[c*2 +: 2];
        win_we  = ch_we_i[c];
        win_dat = ch_dat_i[c*16 +: 16];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = BUS;
      BUS:     if (fml_ack_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      grant     <= '0;
      rr_ptr    <= GW'(N_CH - 1);
      fml_adr_o <= '0;
      fml_stb_o <= 1'b0;
      fml_we_o  <= 1'b0;
      fml_sel_o <= '0;
      fml_do    <= '0;
      ch_dat_o  <= '0;
      ch_ack_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            grant     <= win;
            fml_adr_o <= {win_adr, 1'b0};
            fml_we_o  <= win_we;
            fml_sel_o <= win_sel;
            fml_do    <= win_dat;
            fml_stb_o <= 1'b1;
            if (win_rr)
              rr_ptr <= rr_win;
          end
        end
        BUS: begin
          if (fml_ack_i) begin
            fml_stb_o <= 1'b0;
            ch_ack_o  <= N_CH'(1) << grant;
            if (!fml_we_o)
              ch_dat_o <= fml_di;
          end
        end
        DONE: begin
          ch_ack_o <= '0;
        end
        default: begin
          fml_stb_o <= 1'b0;
          ch_ack_o  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fml_mport_arb.sv
// Directed plus randomized bench for vga_fml_mport_arb with a transaction-level arbitration model.
module tb_vga_fml_mport_arb;
  localparam int N   = 3;
  localparam int AW  = 19;
  localparam int LIM = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] ch_adr;
  logic [2*N-1:0]  ch_sel;
  logic [N-1:0]    ch_we;
  logic [16*N-1:0] ch_dat;
  logic [N-1:0]    ch_stb;
  logic [15:0]     ch_dat_o;
  logic [N-1:0]    ch_ack_o;
  logic [19:0]     fml_adr;
  logic            fml_stb;
  logic            fml_we;
  logic [1:0]      fml_sel;
  logic [15:0]     fml_do;
  logic            fml_ack;
  logic [15:0]     fml_di;

  int tests = 0;
  int fails = 0;
  int m_rr;
  int m_starve;
  logic [15:0] m_dat;
  int got;
  int seq[6];

  vga_fml_mport_arb #(.N_CH(N), .FML_DEPTH(20), .STARVE_LIMIT(LIM)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .ch_adr_i(ch_adr), .ch_sel_i(ch_sel), .ch_we_i(ch_we), .ch_dat_i(ch_dat), .ch_stb_i(ch_stb),
    .ch_dat_o(ch_dat_o), .ch_ack_o(ch_ack_o),
    .fml_adr_o(fml_adr), .fml_stb_o(fml_stb), .fml_we_o(fml_we), .fml_sel_o(fml_sel), .fml_do(fml_do),
    .fml_ack_i(fml_ack), .fml_di(fml_di)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = N - 1;
    m_starve = 0;
    m_dat = '0;
  endtask

  // Chooses the served channel from the requests present at an arbitration point and advances the model.
  function automatic int pick(input logic [N-1:0] stb);
    int  w;
    int  c;
    bit  others;
    bit  starve;
    w = -1;
    others = |stb[N-1:1];
    starve = 1'b0;
`ifdef VGA_FML_ARB_STARVE_EN
    starve = others && (m_starve == LIM);
`endif
    if (stb[0] && !starve) begin
      w = 0;
      if (others) m_starve++;
    end else begin
      for (int k = 1; k < N; k++) begin
        c = (m_rr + k - 1) % (N - 1) + 1;
        if (w < 0 && stb[c]) w = c;
      end
      m_rr = w;
      m_starve = 0;
    end
    return w;
  endfunction

  task automatic set_req(input int c, input logic [18:0] a, input logic [1:0] s,
                         input logic we, input logic [15:0] d);
    ch_adr[c*AW +: AW] = a;
    ch_sel[c*2 +: 2]   = s;
    ch_we[c]           = we;
    ch_dat[c*16 +: 16] = d;
    ch_stb[c]          = 1'b1;
  endtask

  task automatic rand_req(input int c);
    set_req(c, 19'($urandom), 2'($urandom), 1'($urandom), 16'($urandom));
  endtask

  // Entered at a negedge with the DUT idle and at least one stb high; returns at the negedge after DONE.
  task automatic xfer(input int dly, input logic [15:0] di, output int served);
    int w;
    w = pick(ch_stb);
    @(posedge clk); @(negedge clk);
    chk("bus_stb", fml_stb, 1'b1);
    chk("bus_adr", fml_adr, {ch_adr[w*AW +: AW], 1'b0});
    chk("bus_we", fml_we, ch_we[w]);
    chk("bus_sel", fml_sel, ch_sel[w*2 +: 2]);
    chk("bus_do", fml_do, ch_dat[w*16 +: 16]);
    chk("bus_noack", ch_ack_o, '0);
    repeat (dly) begin
      @(negedge clk);
      chk("hold_stb", fml_stb, 1'b1);
      chk("hold_adr", fml_adr, {ch_adr[w*AW +: AW], 1'b0});
      chk("hold_noack", ch_ack_o, '0);
    end
    fml_ack = 1'b1;
    fml_di  = di;
    @(posedge clk); #1;
    fml_ack = 1'b0;
    fml_di  = 16'($urandom);
    @(negedge clk);
    if (!ch_we[w]) m_dat = di;
    chk("ack", ch_ack_o, 32'(1) << w);
    chk("rdat", ch_dat_o, m_dat);
    chk("stb_drop", fml_stb, 1'b0);
    served = -1;
    for (int i = 0; i < N; i++) if (ch_ack_o[i]) served = i;
    @(posedge clk); @(negedge clk);
    chk("ack_pulse", ch_ack_o, '0);
    chk("no_regrant", fml_stb, 1'b0);
    ch_stb[w] = 1'b0;
  endtask

  task automatic reset_dut();
    ch_stb = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n   = 1'b0;
    fml_ack = 1'b0;
    fml_di  = '0;
    ch_adr  = '0; ch_sel = '0; ch_we = '0; ch_dat = '0; ch_stb = '0;
    model_reset();

    // Reset held with all channels requesting
    for (int c = 0; c < N; c++) rand_req(c);
    repeat (3) @(negedge clk);
    chk("rst_fml_stb", fml_stb, 1'b0);
    chk("rst_ack", ch_ack_o, '0);
    chk("rst_adr", fml_adr, '0);
    chk("rst_dat", ch_dat_o, '0);
    chk("rst_we_sel_do", {fml_we, fml_sel, fml_do}, '0);
    rst_n = 1'b1;
    model_reset();
    xfer(1, 16'h1111, got);
    chk("first_after_rst", got, 0);

    // Single read on ch1
    reset_dut();
    set_req(1, 19'h01234, 2'b11, 1'b0, 16'h5555);
    xfer(2, 16'hBEEF, got);
    chk("single_ch", got, 1);
    chk("single_dat", ch_dat_o, 16'hBEEF);

    // Round-robin between ch1 and ch2
    reset_dut();
    rand_req(1); rand_req(2);
    for (int i = 0; i < 4; i++) begin
      xfer(i % 2, 16'($urandom), got);
      seq[i] = got;
      rand_req(got);
    end
    chk("rr_0", seq[0], 1); chk("rr_1", seq[1], 2);
    chk("rr_2", seq[2], 1); chk("rr_3", seq[3], 2);
    ch_stb = '0;

    // Priority: ch0 over ch2
    reset_dut();
    rand_req(0);
    set_req(2, 19'h7ABCD, 2'b01, 1'b1, 16'hC0DE);
    xfer(0, 16'h0, got);
    chk("prio_first", got, 0);
    xfer(1, 16'h0, got);
    chk("prio_second", got, 2);

    // Starvation behaviour with ch0 and ch1 continuously requesting
    reset_dut();
    rand_req(0); rand_req(1);
    for (int i = 0; i < 6; i++) begin
      xfer(0, 16'($urandom), got);
      seq[i] = got;
      rand_req(got);
    end
`ifdef VGA_FML_ARB_STARVE_EN
    chk("starve_0", seq[0], 0); chk("starve_1", seq[1], 0); chk("starve_2", seq[2], 1);
    chk("starve_3", seq[3], 0); chk("starve_4", seq[4], 0); chk("starve_5", seq[5], 1);
`else
    chk("strict_0", seq[0], 0); chk("strict_2", seq[2], 0); chk("strict_5", seq[5], 0);
`endif
    ch_stb = '0;

    // Reset while waiting in BUS
    reset_dut();
    rand_req(2);
    @(posedge clk); @(negedge clk);
    chk("midbus_stb", fml_stb, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midbus_async_drop", fml_stb, 1'b0);
    chk("midbus_noack", ch_ack_o, '0);
    ch_stb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midbus_idle", fml_stb, 1'b0);
    chk("midbus_idle_ack", ch_ack_o, '0);
    rand_req(1);
    xfer(0, 16'hA5A5, got);
    chk("midbus_restart", got, 1);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      for (int c = 0; c < N; c++)
        if (!ch_stb[c] && ($urandom_range(0, 1) == 1)) rand_req(c);
      if (ch_stb == '0) rand_req($urandom_range(0, N - 1));
      xfer($urandom_range(0, 3), 16'($urandom), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
